// File: rtl/cnn_layer_accel_job_ctrl.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_job_ctrl
//   Accelerator-side responder for the quad job handshake. It takes one job
//   from the interface-clock job port and latches the job descriptor into
//   per-job config registers. It then runs the fetch request/ack/complete
//   exchange, fires a single core_start pulse, and holds job_complete until
//   the host acknowledges it.
//
//   Optional feature macro: JOB_CTRL_TIMEOUT_EN
//     defined   -> a watchdog bounds FETCH_REQ, FETCH_WAIT and DONE_WAIT to
//                  C_TIMEOUT_CYCLES cycles each. On expiry the job finishes
//                  with job_error=1.
//     undefined -> those states wait indefinitely.
//
//   Handshake semantics (all signals on clk_if):
//     job_start / job_accept     : job_start is a level sampled only in IDLE.
//                                  job_accept pulses for one cycle in ACCEPT.
//                                  The descriptor is latched on the same edge
//                                  that leaves IDLE.
//     job_fetch_request / ack    : the request is held until ack is sampled 1.
//                                  It drops the cycle after.
//     job_fetch_complete         : honoured only together with ack in
//                                  FETCH_REQ, or in FETCH_WAIT.
//     job_complete / ack         : job_complete is held until the ack is
//                                  sampled 1. It drops the cycle after.
// ---------------------------------------------------------------------------
module cnn_layer_accel_job_ctrl #(
  parameter int C_PARAM_WIDTH    = 128,
  parameter int C_TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk_if,
  input  logic                     rst,
  input  logic                     job_start,
  output logic                     job_accept,
  input  logic [C_PARAM_WIDTH-1:0] job_parameters,
  output logic                     job_fetch_request,
  input  logic                     job_fetch_ack,
  input  logic                     job_fetch_complete,
  output logic                     job_complete,
  input  logic                     job_complete_ack,
  output logic                     core_start,
  input  logic                     core_done,
  output logic                     job_error,
  output logic                     busy,
  output logic [9:0]               num_output_rows_cfg,
  output logic [9:0]               num_output_cols_cfg,
  output logic [6:0]               num_kernel_cfg,
  output logic [4:0]               kernel_size_cfg,
  output logic [4:0]               padding_cfg,
  output logic [6:0]               convolution_stride_cfg,
  output logic                     upsample_cfg,
  output logic [9:0]               pfb_full_count_cfg,
  output logic [7:0]               kernel_full_count_cfg,
  output logic [6:0]               kernel_group_cfg,
  output logic [11:0]              pix_seq_data_full_count_cfg
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ACCEPT     = 3'd1,
    S_FETCH_REQ  = 3'd2,
    S_FETCH_WAIT = 3'd3,
    S_RUN        = 3'd4,
    S_DONE_WAIT  = 3'd5,
    S_COMPLETE   = 3'd6
  } state_t;

  state_t state;
  state_t next_state;

  logic load_cfg;
  logic err_clear;
  logic err_set;
  logic bad_desc;

  // A descriptor that would make the datapath divide by, or loop over, zero
  // is rejected without touching the fetch or core interfaces.
  assign bad_desc = (kernel_size_cfg == 5'd0) ||
                    (convolution_stride_cfg == 7'd0) ||
                    (num_kernel_cfg == 7'd0);

`ifdef JOB_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(C_TIMEOUT_CYCLES);

  logic [CW-1:0] to_cnt;
  logic          to_hit;
  logic          unused_jp;

  assign to_hit    = (to_cnt == CW'(C_TIMEOUT_CYCLES - 1));
  assign unused_jp = ^job_parameters[C_PARAM_WIDTH-1:82];

  // Watchdog: restarts on every state change and counts cycles in wait states.
  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (next_state != state) begin
      to_cnt <= '0;
    end else if ((state == S_FETCH_REQ) || (state == S_FETCH_WAIT) ||
                 (state == S_DONE_WAIT)) begin
      to_cnt <= to_cnt + CW'(1);
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{job_parameters[C_PARAM_WIDTH-1:82],
                        (C_TIMEOUT_CYCLES >= 2)};
`endif

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and Moore outputs decoded from the current state.
  always_comb begin
    next_state        = state;
    load_cfg          = 1'b0;
    err_clear         = 1'b0;
    err_set           = 1'b0;
    job_accept        = 1'b0;
    job_fetch_request = 1'b0;
    core_start        = 1'b0;
    job_complete      = 1'b0;
    busy              = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (job_start) begin
          next_state = S_ACCEPT;
          load_cfg   = 1'b1;
          err_clear  = 1'b1;
        end
      end
      S_ACCEPT: begin
        job_accept = 1'b1;
        if (bad_desc) begin
          next_state = S_COMPLETE;
          err_set    = 1'b1;
        end else begin
          next_state = S_FETCH_REQ;
        end
      end
      S_FETCH_REQ: begin
        job_fetch_request = 1'b1;
        if (job_fetch_ack) begin
          next_state = job_fetch_complete ? S_RUN : S_FETCH_WAIT;
        end
`ifdef JOB_CTRL_TIMEOUT_EN
        else if (to_hit) begin
          next_state = S_COMPLETE;
          err_set    = 1'b1;
        end
`endif
      end
      S_FETCH_WAIT: begin
        if (job_fetch_complete) begin
          next_state = S_RUN;
        end
`ifdef JOB_CTRL_TIMEOUT_EN
        else if (to_hit) begin
          next_state = S_COMPLETE;
          err_set    = 1'b1;
        end
`endif
      end
      S_RUN: begin
        core_start = 1'b1;
        next_state = S_DONE_WAIT;
      end
      S_DONE_WAIT: begin
        if (core_done) begin
          next_state = S_COMPLETE;
        end
`ifdef JOB_CTRL_TIMEOUT_EN
        else if (to_hit) begin
          next_state = S_COMPLETE;
          err_set    = 1'b1;
        end
`endif
      end
      S_COMPLETE: begin
        job_complete = 1'b1;
        if (job_complete_ack) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Sticky per-job error flag: cleared when a job is taken, set on rejection.
  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) begin
      job_error <= 1'b0;
    end else if (err_clear) begin
      job_error <= 1'b0;
    end else if (err_set) begin
      job_error <= 1'b1;
    end
  end

  // Per-job config registers; written only on the edge that accepts a job.
  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) begin
      num_output_rows_cfg         <= '0;
      num_output_cols_cfg         <= '0;
      num_kernel_cfg              <= '0;
      kernel_size_cfg             <= '0;
      padding_cfg                 <= '0;
      convolution_stride_cfg      <= '0;
      upsample_cfg                <= 1'b0;
      pfb_full_count_cfg          <= '0;
      kernel_full_count_cfg       <= '0;
      kernel_group_cfg            <= '0;
      pix_seq_data_full_count_cfg <= '0;
    end else if (load_cfg) begin
      num_output_rows_cfg         <= job_parameters[9:0];
      num_output_cols_cfg         <= job_parameters[19:10];
      num_kernel_cfg              <= job_parameters[26:20];
      kernel_size_cfg             <= job_parameters[31:27];
      padding_cfg                 <= job_parameters[36:32];
      convolution_stride_cfg      <= job_parameters[43:37];
      upsample_cfg                <= job_parameters[44];
      pfb_full_count_cfg          <= job_parameters[54:45];
      kernel_full_count_cfg       <= job_parameters[62:55];
      kernel_group_cfg            <= job_parameters[69:63];
      pix_seq_data_full_count_cfg <= job_parameters[81:70];
    end
  end

endmodule
